uc_multiciclo: RTL and testbench
================================

# uc_multiciclo

Parametrised control unit for the single-cycle educational processor, successor to the purely combinational decoder. It decodes the opcode exactly like its predecessor for arithmetic, immediate-load and jump instructions. It adds registered behaviour: a req/ack handshake for IN/OUT port instructions with PC stall and timeout, a call/return depth counter with overflow/underflow detection, and a HALT state. It sits between instruction memory and the datapath (PC mux, register file, ALU, flag Z, I/O ports, return stack).

## Interface
- OPCODE_W, 6, opcode width; top two bits select class, the rest as below.
- ALU_OP_W, 3, ALU operation width; op_alu = opcode[ALU_OP_W+1:2].
- STACK_DEPTH, 8, return-stack entries in datapath; counter width = clog2(STACK_DEPTH+1).
- TIMEOUT, 255, maximum port-wait cycles before abort; counter width = clog2(TIMEOUT+1).

- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  OPCODE_W  current instruction opcode.
- z  in  1  registered zero flag from datapath.
- port_ack  in  1  port acknowledges transfer.
- s_inc  out  1  1: PC+1, 0: PC ← jump target / stack top (s_ret selects).
- s_ret  out  1  PC source = return stack top.
- s_inm  out  1  register-file write data = immediate.
- s_port  out  1  register-file write data = port input.
- we3  out  1  register-file write enable.
- wez  out  1  Z flag write enable.
- op_alu  out  ALU_OP_W  ALU operation.
- pc_en  out  1  PC load enable (0 = stall).
- port_req, port_we  out  1 each  port request; port_we=1 for OUT.
- push, pop  out  1 each  return-stack control.
- halted, err_port, err_stack  out  1 each  status, sticky.

## Operation
- Opcode classes (6-bit default): 0xxxxx ARITH (we3=1, wez=1, s_inc=1); 1000xx LOADINM (we3, s_inm, s_inc); 100100 JZ, 100101 JNZ (jump when z=1 / z=0, else s_inc=1); 100110 JMP; 100111 CALL; 101000 RET; 101001 IN; 101010 OUT; 111111 HALT; all else NOP (s_inc=1 only).
- States: RUN, PORT_WAIT, HALT.
- RUN: outputs decoded combinationally from opcode and z; pc_en=1 except IN/OUT.
- IN/OUT in RUN: port_req=1, pc_en=0, go PORT_WAIT, clear timeout counter. If port_ack already 1 in same cycle, complete immediately (see completion), stay RUN.
- PORT_WAIT: port_req held 1, port_we held, pc_en=0, counter increments. Completion on port_ack=1: IN → we3=1, s_port=1; both → pc_en=1, s_inc=1, return RUN. Counter reaches TIMEOUT with no ack: err_port←1, pc_en=1, s_inc=1, no write, return RUN.
- CALL: if depth<STACK_DEPTH → push=1, s_inc=0 (jump), depth+1; else err_stack←1, treated as NOP.
- RET: if depth>0 → pop=1, s_ret=1, s_inc=0, depth−1; else err_stack←1, NOP.
- HALT: go HALT; pc_en=0, all enables 0, halted=1; exits only on reset.
- Error flags sticky until reset; do not stop execution.

## Timing
- Reset (synchronous): state=RUN, depth=0, timeout counter=0, halted=err_port=err_stack=0. While reset=1 all enables (we3, wez, pc_en, port_req, push, pop) forced 0, s_inc=1, op_alu=0.
- Reset mid-PORT_WAIT: port_req drops in reset cycle; no write occurs.
- Decode latency 0 cycles (combinational); state/counters update on next edge.
- IN/OUT with ack after N cycles of PORT_WAIT: total N+1 cycles for that instruction; PC advances on the ack edge.
- Timeout: abort on the cycle counter = TIMEOUT; ack arriving in that same cycle wins (normal completion, no error).
- port_ack outside PORT_WAIT/IN/OUT ignored.

## Structure
- Package uc_pkg: opcode class constants, state enum, default parameter values.
- Sub-module uc_decode: combinational opcode/z → control vector; uc_multiciclo wraps it with FSM, counters, and output gating.

## Test plan
- ARITH opcode 6'b010100 → op_alu=3'b101, we3=wez=s_inc=pc_en=1, no state change.
- JZ with z=1 → s_inc=0; with z=0 → s_inc=1; JNZ mirrored.
- IN, ack on 3rd wait cycle → port_req high 4 cycles, pc_en=0 for 3, we3=s_port=1 on ack cycle, err_port=0.
- OUT, no ack, TIMEOUT=4 → abort after 4 wait cycles, err_port=1, PC advances, we3 never 1.
- STACK_DEPTH=2: CALL,CALL,CALL → 2 pushes, third sets err_stack; RET×3 → 2 pops, third no pop.
- HALT then reset asserted mid-PORT_WAIT sequence → halted=1 until reset; after reset all outputs at reset values.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle control unit: opcode encodings,
// instruction classes, FSM states and the control-vector type.
package uc_pkg;

    localparam int OPCODE_W_DEF    = 6;
    localparam int ALU_OP_W_DEF    = 3;
    localparam int STACK_DEPTH_DEF = 8;
    localparam int TIMEOUT_DEF     = 255;

    localparam logic [3:0] OP_LOADINM_PFX = 4'b1000;
    localparam logic [5:0] OP_JZ   = 6'b100100;
    localparam logic [5:0] OP_JNZ  = 6'b100101;
    localparam logic [5:0] OP_JMP  = 6'b100110;
    localparam logic [5:0] OP_CALL = 6'b100111;
    localparam logic [5:0] OP_RET  = 6'b101000;
    localparam logic [5:0] OP_IN   = 6'b101001;
    localparam logic [5:0] OP_OUT  = 6'b101010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [3:0] {
        CL_NOP,
        CL_ARITH,
        CL_LOADINM,
        CL_JZ,
        CL_JNZ,
        CL_JMP,
        CL_CALL,
        CL_RET,
        CL_IN,
        CL_OUT,
        CL_HALT
    } op_class_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PORT_WAIT,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic s_inc;
        logic s_ret;
        logic s_inm;
        logic s_port;
        logic we3;
        logic wez;
        logic pc_en;
        logic port_req;
        logic port_we;
        logic push;
        logic pop;
    } ctrl_t;

    // Sequential fetch with nothing written; the base of every other vector.
    function automatic ctrl_t ctrl_nop(input logic pc_en);
        ctrl_t c;
        c       = '0;
        c.s_inc = 1'b1;
        c.pc_en = pc_en;
        return c;
    endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational opcode/z decoder. Produces the instruction class and the
// control vector assuming the stack and port are always available.
module uc_decode
    import uc_pkg::*;
#(
    parameter int OPCODE_W = OPCODE_W_DEF
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                z,
    output op_class_t           op_class,
    output ctrl_t               ctrl
);

    logic [5:0] op6;
    assign op6 = opcode[OPCODE_W-1 -: 6];

    always_comb begin
        op_class = CL_NOP;
        if (!op6[5]) begin
            op_class = CL_ARITH;
        end else if (op6[5:2] == OP_LOADINM_PFX) begin
            op_class = CL_LOADINM;
        end else begin
            case (op6)
                OP_JZ:   op_class = CL_JZ;
                OP_JNZ:  op_class = CL_JNZ;
                OP_JMP:  op_class = CL_JMP;
                OP_CALL: op_class = CL_CALL;
                OP_RET:  op_class = CL_RET;
                OP_IN:   op_class = CL_IN;
                OP_OUT:  op_class = CL_OUT;
                OP_HALT: op_class = CL_HALT;
                default: op_class = CL_NOP;
            endcase
        end
    end

    always_comb begin
        ctrl = ctrl_nop(1'b1);
        case (op_class)
            CL_ARITH: begin
                ctrl.we3 = 1'b1;
                ctrl.wez = 1'b1;
            end
            CL_LOADINM: begin
                ctrl.we3   = 1'b1;
                ctrl.s_inm = 1'b1;
            end
            CL_JZ:  ctrl.s_inc = ~z;
            CL_JNZ: ctrl.s_inc = z;
            CL_JMP: ctrl.s_inc = 1'b0;
            CL_CALL: begin
                ctrl.push  = 1'b1;
                ctrl.s_inc = 1'b0;
            end
            CL_RET: begin
                ctrl.pop   = 1'b1;
                ctrl.s_ret = 1'b1;
                ctrl.s_inc = 1'b0;
            end
            CL_IN: begin
                ctrl.port_req = 1'b1;
                ctrl.pc_en    = 1'b0;
            end
            CL_OUT: begin
                ctrl.port_req = 1'b1;
                ctrl.port_we  = 1'b1;
                ctrl.pc_en    = 1'b0;
            end
            CL_HALT: ctrl.pc_en = 1'b0;
            default: ctrl = ctrl_nop(1'b1);
        endcase
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: wraps the decoder with the RUN/PORT_WAIT/HALT FSM,
// the port-wait timeout counter, the call depth counter and sticky status.
//
//   state        | meaning
//   ST_RUN       | normal decode, one instruction per cycle
//   ST_PORT_WAIT | IN/OUT issued, PC stalled until ack or timeout
//   ST_HALT      | stopped, everything disabled until reset
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int OPCODE_W    = OPCODE_W_DEF,
    parameter int ALU_OP_W    = ALU_OP_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                z,
    input  logic                port_ack,
    output logic                s_inc,
    output logic                s_ret,
    output logic                s_inm,
    output logic                s_port,
    output logic                we3,
    output logic                wez,
    output logic [ALU_OP_W-1:0] op_alu,
    output logic                pc_en,
    output logic                port_req,
    output logic                port_we,
    output logic                push,
    output logic                pop,
    output logic                halted,
    output logic                err_port,
    output logic                err_stack
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(TIMEOUT);

    op_class_t op_class;
    ctrl_t     dec_ctrl;
    ctrl_t     ctrl;

    state_t             state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_out_q, is_out_d;
    logic               err_port_q, err_port_d;
    logic               err_stack_q, err_stack_d;

    uc_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode   (opcode),
        .z        (z),
        .op_class (op_class),
        .ctrl     (dec_ctrl)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            depth_q     <= '0;
            cnt_q       <= '0;
            is_out_q    <= 1'b0;
            err_port_q  <= 1'b0;
            err_stack_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            cnt_q       <= cnt_d;
            is_out_q    <= is_out_d;
            err_port_q  <= err_port_d;
            err_stack_q <= err_stack_d;
        end
    end

    always_comb begin
        ctrl        = dec_ctrl;
        state_d     = state_q;
        depth_d     = depth_q;
        cnt_d       = cnt_q;
        is_out_d    = is_out_q;
        err_port_d  = err_port_q;
        err_stack_d = err_stack_q;

        case (state_q)
            ST_RUN: begin
                case (op_class)
                    CL_CALL: begin
                        if (depth_q < DEPTH_MAX) begin
                            depth_d = depth_q + 1'b1;
                        end else begin
                            ctrl        = ctrl_nop(1'b1);
                            err_stack_d = 1'b1;
                        end
                    end
                    CL_RET: begin
                        if (depth_q != '0) begin
                            depth_d = depth_q - 1'b1;
                        end else begin
                            ctrl        = ctrl_nop(1'b1);
                            err_stack_d = 1'b1;
                        end
                    end
                    CL_IN, CL_OUT: begin
                        cnt_d    = '0;
                        is_out_d = (op_class == CL_OUT);
                        if (port_ack) begin
                            ctrl.pc_en  = 1'b1;
                            ctrl.we3    = (op_class == CL_IN);
                            ctrl.s_port = (op_class == CL_IN);
                        end else begin
                            state_d = ST_PORT_WAIT;
                        end
                    end
                    CL_HALT: state_d = ST_HALT;
                    default: ;
                endcase
            end
            ST_PORT_WAIT: begin
                ctrl          = ctrl_nop(1'b0);
                ctrl.port_req = 1'b1;
                ctrl.port_we  = is_out_q;
                cnt_d         = cnt_q + 1'b1;
                // An ack in the timeout cycle still counts as a normal completion.
                if (port_ack) begin
                    ctrl.pc_en  = 1'b1;
                    ctrl.we3    = ~is_out_q;
                    ctrl.s_port = ~is_out_q;
                    state_d     = ST_RUN;
                end else if (cnt_d == CNT_MAX) begin
                    ctrl.pc_en = 1'b1;
                    err_port_d = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_HALT: ctrl = ctrl_nop(1'b0);
            default: begin
                ctrl    = ctrl_nop(1'b0);
                state_d = ST_RUN;
            end
        endcase

        if (reset) begin
            ctrl = ctrl_nop(1'b0);
        end
    end

    assign s_inc     = ctrl.s_inc;
    assign s_ret     = ctrl.s_ret;
    assign s_inm     = ctrl.s_inm;
    assign s_port    = ctrl.s_port;
    assign we3       = ctrl.we3;
    assign wez       = ctrl.wez;
    assign pc_en     = ctrl.pc_en;
    assign port_req  = ctrl.port_req;
    assign port_we   = ctrl.port_we;
    assign push      = ctrl.push;
    assign pop       = ctrl.pop;
    assign op_alu    = reset ? '0 : opcode[ALU_OP_W+1:2];
    assign halted    = (state_q == ST_HALT);
    assign err_port  = err_port_q;
    assign err_stack = err_stack_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Bench for uc_multiciclo with STACK_DEPTH=2, TIMEOUT=4: a per-cycle model
// checked at every falling edge plus directed literal expectations.
module tb_uc_multiciclo;

    localparam int TO = 4;
    localparam int SD = 2;

    localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;
    localparam int C_NOP = 0, C_AR = 1, C_LD = 2, C_JZ = 3, C_JNZ = 4, C_JMP = 5,
                   C_CALL = 6, C_RET = 7, C_IN = 8, C_OUT = 9, C_HALT = 10;

    localparam logic [5:0] ARITH = 6'b010100, LDI = 6'b100001, JZ = 6'b100100,
                           JNZ = 6'b100101, JMP = 6'b100110, CALL = 6'b100111,
                           RET = 6'b101000, IN = 6'b101001, OUT = 6'b101010,
                           HALT = 6'b111111, NOP = 6'b110000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] opcode = ARITH;
    logic z = 1'b0;
    logic port_ack = 1'b0;
    logic s_inc, s_ret, s_inm, s_port, we3, wez, pc_en, port_req, port_we, push, pop;
    logic [2:0] op_alu;
    logic halted, err_port, err_stack;

    int n_tests = 0;
    int n_fail = 0;

    int m_mode, m_wait, m_depth;
    logic m_out, m_errp, m_errs;
    int n_mode, n_wait, n_depth;
    logic n_out, n_errp, n_errs;

    bit st_en = 0;
    int st_req, st_pcen0, st_we3, st_push, st_pop;

    always #5 clk = ~clk;

    uc_multiciclo #(
        .OPCODE_W(6), .ALU_OP_W(3), .STACK_DEPTH(SD), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .port_ack(port_ack),
        .s_inc(s_inc), .s_ret(s_ret), .s_inm(s_inm), .s_port(s_port),
        .we3(we3), .wez(wez), .op_alu(op_alu), .pc_en(pc_en),
        .port_req(port_req), .port_we(port_we), .push(push), .pop(pop),
        .halted(halted), .err_port(err_port), .err_stack(err_stack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int cls(input logic [5:0] o);
        casez (o)
            6'b0?????: return C_AR;
            6'b1000??: return C_LD;
            6'b100100: return C_JZ;
            6'b100101: return C_JNZ;
            6'b100110: return C_JMP;
            6'b100111: return C_CALL;
            6'b101000: return C_RET;
            6'b101001: return C_IN;
            6'b101010: return C_OUT;
            6'b111111: return C_HALT;
            default:   return C_NOP;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode = M_RUN; m_wait = 0; m_depth = 0;
            m_out = 0; m_errp = 0; m_errs = 0;
        end else begin
            m_mode = n_mode; m_wait = n_wait; m_depth = n_depth;
            m_out = n_out; m_errp = n_errp; m_errs = n_errs;
        end
    end

    always @(negedge clk) begin : cmp
        logic e_inc, e_ret, e_inm, e_port, e_we3, e_wez, e_pc, e_req, e_pwe, e_push, e_pop;
        logic [2:0] e_alu;
        int c;
        e_inc = 1; e_ret = 0; e_inm = 0; e_port = 0; e_we3 = 0; e_wez = 0;
        e_pc = 0; e_req = 0; e_pwe = 0; e_push = 0; e_pop = 0;
        n_mode = m_mode; n_wait = m_wait; n_depth = m_depth;
        n_out = m_out; n_errp = m_errp; n_errs = m_errs;
        e_alu = opcode[4:2];
        if (reset) begin
            e_alu = 3'b000;
        end else if (m_mode == M_RUN) begin
            c = cls(opcode);
            e_pc = 1;
            case (c)
                C_AR:  begin e_we3 = 1; e_wez = 1; end
                C_LD:  begin e_we3 = 1; e_inm = 1; end
                C_JZ:  e_inc = !z;
                C_JNZ: e_inc = z;
                C_JMP: e_inc = 0;
                C_CALL: if (m_depth < SD) begin
                    e_push = 1; e_inc = 0; n_depth = m_depth + 1;
                end else n_errs = 1;
                C_RET: if (m_depth > 0) begin
                    e_pop = 1; e_ret = 1; e_inc = 0; n_depth = m_depth - 1;
                end else n_errs = 1;
                C_IN, C_OUT: begin
                    e_req = 1; e_pwe = (c == C_OUT);
                    if (port_ack) begin
                        e_we3 = (c == C_IN); e_port = (c == C_IN);
                    end else begin
                        e_pc = 0; n_mode = M_WAIT; n_wait = 0; n_out = (c == C_OUT);
                    end
                end
                C_HALT: begin e_pc = 0; n_mode = M_HALT; end
                default: ;
            endcase
        end else if (m_mode == M_WAIT) begin
            e_req = 1; e_pwe = m_out;
            if (port_ack) begin
                e_pc = 1; e_we3 = !m_out; e_port = !m_out; n_mode = M_RUN;
            end else if (m_wait + 1 == TO) begin
                e_pc = 1; n_errp = 1; n_mode = M_RUN;
            end else begin
                n_wait = m_wait + 1;
            end
        end
        check("ctrl", {21'd0, s_inc, s_ret, s_inm, s_port, we3, wez, pc_en, port_req, port_we, push, pop},
              {21'd0, e_inc, e_ret, e_inm, e_port, e_we3, e_wez, e_pc, e_req, e_pwe, e_push, e_pop});
        check("op_alu", {29'd0, op_alu}, {29'd0, e_alu});
        check("status", {29'd0, halted, err_port, err_stack},
              {29'd0, (m_mode == M_HALT), m_errp, m_errs});
        if (st_en) begin
            st_req   += int'(port_req);
            st_pcen0 += int'(!pc_en);
            st_we3   += int'(we3);
            st_push  += int'(push);
            st_pop   += int'(pop);
        end
    end

    task automatic step(input logic [5:0] o, input logic zz, input logic ack);
        @(posedge clk);
        #1;
        opcode = o; z = zz; port_ack = ack;
        @(negedge clk);
        #1;
    endtask

    task automatic stats_clear();
        st_req = 0; st_pcen0 = 0; st_we3 = 0; st_push = 0; st_pop = 0; st_en = 1;
    endtask

    initial begin
        step(ARITH, 0, 0);
        check("rst_pc_en", {31'd0, pc_en}, 32'd0);
        check("rst_s_inc_alu", {28'd0, s_inc, op_alu}, {28'd0, 1'b1, 3'b000});
        step(ARITH, 0, 1);
        reset = 0;

        step(ARITH, 0, 0);
        check("arith", {26'd0, op_alu, we3, wez, s_inc, pc_en}, {26'd0, 3'b101, 4'b1111});
        check("arith_status", {29'd0, halted, err_port, err_stack}, 32'd0);
        step(LDI, 0, 0);
        check("ldi", {29'd0, s_inm, we3, wez}, {29'd0, 3'b110});
        step(JZ, 1, 0);  check("jz_z1", {31'd0, s_inc}, 32'd0);
        step(JZ, 0, 0);  check("jz_z0", {31'd0, s_inc}, 32'd1);
        step(JNZ, 1, 0); check("jnz_z1", {31'd0, s_inc}, 32'd1);
        step(JNZ, 0, 0); check("jnz_z0", {31'd0, s_inc}, 32'd0);
        step(JMP, 0, 0); check("jmp", {31'd0, s_inc}, 32'd0);
        step(NOP, 0, 1); check("nop_ack_ignored", {29'd0, s_inc, pc_en, we3}, {29'd0, 3'b110});

        // IN acknowledged on the third wait cycle.
        stats_clear();
        step(IN, 0, 0);
        step(IN, 0, 0);
        step(IN, 0, 0);
        step(IN, 0, 1);
        check("in_ack_we3_sport", {30'd0, we3, s_port}, {30'd0, 2'b11});
        st_en = 0;
        check("in_req_cycles", st_req, 4);
        check("in_stall_cycles", st_pcen0, 3);
        step(NOP, 0, 0);
        check("in_no_err", {30'd0, err_port, port_req}, 32'd0);

        // Ack in the very cycle the counter reaches TIMEOUT: normal completion.
        step(IN, 0, 0);
        for (int i = 0; i < TO - 1; i++) step(IN, 0, 0);
        step(IN, 0, 1);
        check("in_ack_at_timeout", {31'd0, we3}, 32'd1);
        step(NOP, 0, 0);
        check("ack_at_timeout_no_err", {31'd0, err_port}, 32'd0);

        step(OUT, 0, 1);
        check("out_immediate", {29'd0, pc_en, port_we, we3}, {29'd0, 3'b110});

        // OUT never acknowledged: abort after TIMEOUT wait cycles.
        stats_clear();
        for (int i = 0; i < TO + 1; i++) step(OUT, 0, 0);
        check("out_abort_pc", {30'd0, pc_en, s_inc}, {30'd0, 2'b11});
        st_en = 0;
        check("out_stall_cycles", st_pcen0, 4);
        check("out_never_we3", st_we3, 0);
        step(NOP, 0, 0);
        check("out_err_port", {31'd0, err_port}, 32'd1);

        stats_clear();
        step(CALL, 0, 0);
        step(CALL, 0, 0);
        step(CALL, 0, 0);
        check("call3_nop", {30'd0, push, s_inc}, {30'd0, 2'b01});
        step(RET, 0, 0);
        step(RET, 0, 0);
        step(RET, 0, 0);
        check("ret3_nop", {29'd0, pop, s_ret, s_inc}, {29'd0, 3'b001});
        st_en = 0;
        check("push_count", st_push, 2);
        check("pop_count", st_pop, 2);
        check("err_stack_set", {31'd0, err_stack}, 32'd1);

        step(HALT, 0, 0);
        check("halt_cycle", {31'd0, pc_en}, 32'd0);
        step(IN, 0, 0);
        check("halted", {30'd0, halted, port_req}, {30'd0, 2'b10});
        step(ARITH, 0, 1);
        check("halted_no_write", {29'd0, we3, wez, pc_en}, 32'd0);

        reset = 1;
        step(NOP, 0, 0);
        reset = 0;
        step(NOP, 0, 0);
        check("post_reset_status", {29'd0, halted, err_port, err_stack}, 32'd0);
        check("post_reset_run", {31'd0, pc_en}, 32'd1);

        step(IN, 0, 0);
        step(IN, 0, 0);
        check("wait_req", {30'd0, port_req, pc_en}, {30'd0, 2'b10});
        reset = 1;
        step(IN, 0, 1);
        check("reset_mid_wait", {28'd0, port_req, we3, pc_en, s_inc}, {28'd0, 4'b0001});
        reset = 0;
        step(ARITH, 0, 0);
        check("after_reset_arith", {29'd0, we3, pc_en, halted}, {29'd0, 3'b110});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
